capture_reg_arbiter: RTL and testbench

CAPTURE_REG_ARBITER -- requirements
Module: capture_reg_arbiter

---
 rtl/capture_reg_arbiter_pkg.sv | 42 ++++
 rtl/capture_reg_arbiter_rr_pick.sv | 58 +++++
 rtl/capture_reg_arbiter.sv | 169 ++++++++++++++++
 tb/tb_capture_reg_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/capture_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cap_arb_pkg
//
// Purpose:
//   Shared definitions for the capture register arbiter. It holds the FSM
//   state encoding, the width of the requester index (and so of q_owner),
//   and a helper that advances a round-robin pointer with wrap-around.
//
// Contents:
//   OWNER_W     - width of a requester index; covers up to 8 requesters
//   MAX_REQ     - largest requester count an OWNER_W-bit index can address
//   state_t     - IDLE / GRANT / CAPTURE / COOL
//   wrap_inc()  - (idx + 1) mod n for an index already below n
// ---------------------------------------------------------------------------
package cap_arb_pkg;

  localparam int OWNER_W = 3;
  localparam int MAX_REQ = 1 << OWNER_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2,
    COOL    = 2'd3
  } state_t;

  // The index is always below n, so wrapping only needs one compare
  // rather than a general modulo.
  function automatic logic [OWNER_W-1:0] wrap_inc(
    input logic [OWNER_W-1:0] idx,
    input int                 n
  );
    logic [OWNER_W-1:0] result;
    if (int'(idx) >= n - 1) begin
      result = '0;
    end else begin
      result = idx + 1'b1;
    end
    return result;
  endfunction

endpackage : cap_arb_pkg

// File: rtl/capture_reg_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purpose:
//   Combinational round-robin winner select. The search begins at ptr and
//   walks upward, wrapping from NREQ-1 back to 0. The first set request
//   bit found wins.
//
// Ports:
//   req    in   NREQ      request vector
//   ptr    in   OWNER_W   requester with highest priority this round
//   valid  out  1         at least one request bit is set
//   idx    out  OWNER_W   index of the winning requester (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick
  import cap_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] idx
);

  // The request vector is zero-extended to the full index range. This lets
  // a 3-bit candidate index it without an out-of-range select.
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  // Candidates are ptr, ptr+1, ... taken modulo NREQ. Because ptr < NREQ
  // and the offset is < NREQ, a single conditional subtract wraps the sum.
  // The found flag keeps the lowest offset, which is the nearest requester
  // at or after ptr.
  always_comb begin
    logic [OWNER_W:0] cand;
    logic             found;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (OWNER_W+1)'(ptr) + (OWNER_W+1)'(k);
      if (cand >= (OWNER_W+1)'(NREQ)) begin
        cand = cand - (OWNER_W+1)'(NREQ);
      end
      if (!found && req_ext[cand[OWNER_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[OWNER_W-1:0];
      end
    end
    valid = found;
  end

endmodule : rr_pick

// File: rtl/capture_reg_arbiter.sv
// ---------------------------------------------------------------------------
// capture_reg_arbiter
//
// Purpose:
//   Arbitrates NREQ requesters for one shared edge-triggered capture
//   register. Each transaction takes four cycles:
//     IDLE -> GRANT -> CAPTURE -> COOL -> IDLE
//   - In IDLE, a round-robin winner is chosen and its grant is registered.
//   - In GRANT, the winner's request is checked again. If it has dropped,
//     the transaction aborts and no data is captured.
//   - In CAPTURE, cap_en is high. The register loads the winner's data on
//     the edge that ends this state.
//   - COOL is a single spacer cycle.
//   The round-robin pointer moves past the winner only when a capture
//   completes.
//
// Ports:
//   clk      in   1            rising-edge clock
//   rst_n    in   1            asynchronous active-low reset
//   req      in   NREQ         level requests, held until granted
//   wdata    in   NREQ*WIDTH   requester i data in [i*WIDTH +: WIDTH]
//   gnt      out  NREQ         registered one-hot grant
//   cap_en   out  1            registered capture enable
//   q        out  WIDTH        shared capture register
//   q_owner  out  3            requester whose data is held in q
//   busy     out  1            high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module capture_reg_arbiter
  import cap_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  cap_en,
  output logic [WIDTH-1:0]      q,
  output logic [OWNER_W-1:0]    q_owner,
  output logic                  busy
);

  state_t               state;
  state_t               state_next;
  logic [OWNER_W-1:0]   win;
  logic [OWNER_W-1:0]   win_next;
  logic [OWNER_W-1:0]   rr_ptr;
  logic [OWNER_W-1:0]   rr_next;
  logic [NREQ-1:0]      gnt_next;
  logic                 cap_en_next;

  logic                 pick_valid;
  logic [OWNER_W-1:0]   pick_idx;

  logic [MAX_REQ-1:0]   req_ext;
  logic [WIDTH-1:0]     wdata_lane [MAX_REQ];

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The request and data inputs are widened to the full 3-bit index range.
  // The stored winner index can then select from them directly. Lanes at
  // or above NREQ read as zero; they are never selected.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  for (genvar g = 0; g < MAX_REQ; g++) begin : g_lane
    if (g < NREQ) begin : g_used
      assign wdata_lane[g] = wdata[g*WIDTH +: WIDTH];
    end else begin : g_unused
      assign wdata_lane[g] = '0;
    end
  end

  assign busy = (state != IDLE);

  // Next-state logic and the next values of every registered output.
  // - Grant and winner hold their value unless a state changes them.
  // - cap_en defaults low, so it is high for the CAPTURE cycle only.
  // - Only changes to the winner's request matter after IDLE. Other
  //   request bits are not examined until the FSM returns there.
  always_comb begin
    state_next  = state;
    win_next    = win;
    rr_next     = rr_ptr;
    gnt_next    = gnt;
    cap_en_next = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          win_next   = pick_idx;
          gnt_next   = NREQ'(1) << pick_idx;
        end
      end

      GRANT: begin
        if (req_ext[win]) begin
          state_next  = CAPTURE;
          cap_en_next = 1'b1;
        end else begin
          // Abort: drop the grant and keep the pointer where it is, so the
          // same priority order applies to the next round.
          state_next = IDLE;
          gnt_next   = '0;
        end
      end

      CAPTURE: begin
        state_next = COOL;
        gnt_next   = '0;
        rr_next    = wrap_inc(win, NREQ);
      end

      COOL: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State and registered outputs. Reset clears any transaction in flight,
  // including one already in CAPTURE, so nothing is captured and the
  // pointer does not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      win    <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      cap_en <= 1'b0;
    end else begin
      state  <= state_next;
      win    <= win_next;
      rr_ptr <= rr_next;
      gnt    <= gnt_next;
      cap_en <= cap_en_next;
    end
  end

  // The shared capture register. It changes only on an edge where the
  // registered cap_en is high. The data lane is read on that same edge, so
  // changes to wdata earlier in the transaction have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_owner <= '0;
    end else if (cap_en) begin
      q       <= wdata_lane[win];
      q_owner <= win;
    end
  end

endmodule : capture_reg_arbiter

// File: tb/tb_capture_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_capture_reg_arbiter
//
// Directed bench for capture_reg_arbiter with NREQ=4 and WIDTH=8. Inputs
// are driven 1 ns after each rising edge. Outputs are checked at the same
// point, so each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_capture_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  cap_en;
  logic [WIDTH-1:0]      q;
  logic [2:0]            q_owner;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  capture_reg_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .cap_en  (cap_en),
    .q       (q),
    .q_owner (q_owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] w);
    req   = r;
    wdata = w;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks gnt, cap_en, q, q_owner, busy and the round-robin pointer.
  task automatic check_all(input string tag, input logic [3:0] e_gnt,
                           input logic e_cap, input logic [7:0] e_q,
                           input logic [2:0] e_own, input logic e_busy,
                           input logic [2:0] e_rr);
    check_output({tag, ".gnt"},     32'(gnt),        32'(e_gnt));
    check_output({tag, ".cap_en"},  32'(cap_en),     32'(e_cap));
    check_output({tag, ".q"},       32'(q),          32'(e_q));
    check_output({tag, ".q_owner"}, 32'(q_owner),    32'(e_own));
    check_output({tag, ".busy"},    32'(busy),       32'(e_busy));
    check_output({tag, ".rr_ptr"},  32'(dut.rr_ptr), 32'(e_rr));
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(4'b0000, 32'h0000_0000);
    tick();
    tick();

    // Reset state
    check_all("reset", 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick();
    check_all("post_reset_idle", 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0);

    // Single request from requester 2
    $display("[TB] single request");
    apply_stimulus(4'b0100, 32'h00A5_0000);
    tick();
    check_all("single.grant", 4'b0100, 1'b0, 8'h00, 3'd0, 1'b1, 3'd0);
    // wdata changes during GRANT are accepted; the CAPTURE-cycle value wins
    apply_stimulus(4'b0100, 32'h00A5_0000);
    tick();
    check_output("single.cap_en", 32'(cap_en), 32'd1);
    check_output("single.q_before", 32'(q), 32'h00);
    apply_stimulus(4'b0000, 32'h00A5_0000);
    tick();
    check_all("single.cool", 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b1, 3'd3);
    tick();
    check_all("single.idle", 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b0, 3'd3);

    // Hold: wdata toggles with no request for 20 cycles
    $display("[TB] hold");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(4'b0000, (i % 2 == 0) ? 32'h5A5A_5A5A : 32'hFFFF_FFFF);
      tick();
      check_output("hold.q", 32'(q), 32'hA5);
      check_output("hold.cap_en", 32'(cap_en), 32'd0);
    end

    // Wrap-around: rr_ptr=3, req=1001 -> 3 then 0
    $display("[TB] wrap-around");
    apply_stimulus(4'b1001, 32'h3300_0011);
    tick();
    check_all("wrap.grant3", 4'b1000, 1'b0, 8'hA5, 3'd2, 1'b1, 3'd3);
    tick();
    check_output("wrap.cap3", 32'(cap_en), 32'd1);
    apply_stimulus(4'b0001, 32'h3300_0011);
    tick();
    check_all("wrap.cool3", 4'b0000, 1'b0, 8'h33, 3'd3, 1'b1, 3'd0);
    tick();
    check_output("wrap.idle", 32'(busy), 32'd0);
    tick();
    check_all("wrap.grant0", 4'b0001, 1'b0, 8'h33, 3'd3, 1'b1, 3'd0);
    tick();
    check_output("wrap.cap0", 32'(cap_en), 32'd1);
    apply_stimulus(4'b0000, 32'h3300_0011);
    tick();
    check_all("wrap.cool0", 4'b0000, 1'b0, 8'h11, 3'd0, 1'b1, 3'd1);
    tick();

    // Abort: req[1] drops during GRANT
    $display("[TB] abort");
    apply_stimulus(4'b0010, 32'h0000_7700);
    tick();
    check_all("abort.grant", 4'b0010, 1'b0, 8'h11, 3'd0, 1'b1, 3'd1);
    apply_stimulus(4'b0000, 32'h0000_7700);
    tick();
    check_all("abort.idle", 4'b0000, 1'b0, 8'h11, 3'd0, 1'b0, 3'd1);
    tick();
    check_all("abort.stays", 4'b0000, 1'b0, 8'h11, 3'd0, 1'b0, 3'd1);

    // Reset mid-CAPTURE
    $display("[TB] reset mid-capture");
    apply_stimulus(4'b0100, 32'h005A_0000);
    tick();
    tick();
    check_output("rstcap.cap_en_before", 32'(cap_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all("rstcap.async", 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0);
    apply_stimulus(4'b0000, 32'h005A_0000);
    tick();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("rstcap.q_held", 32'(q), 32'h00);
      check_output("rstcap.cap_en_low", 32'(cap_en), 32'd0);
    end

    // Fairness: req=1111 for 16 cycles from rr_ptr=0
    $display("[TB] fairness");
    apply_stimulus(4'b1111, 32'h4433_2211);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 4 == 1) begin
        check_output($sformatf("fair.gnt_c%0d", c), 32'(gnt),
                     32'(4'b0001 << ((c - 1) / 4)));
      end else if (c % 4 == 2) begin
        check_output($sformatf("fair.cap_c%0d", c), 32'(cap_en), 32'd1);
      end else if (c % 4 == 3) begin
        check_output($sformatf("fair.q_c%0d", c), 32'(q),
                     32'(8'h11 * (((c - 3) / 4) + 1)));
        check_output($sformatf("fair.own_c%0d", c), 32'(q_owner),
                     32'((c - 3) / 4));
        check_output($sformatf("fair.gnt0_c%0d", c), 32'(gnt), 32'd0);
      end else begin
        check_output($sformatf("fair.gnt0_c%0d", c), 32'(gnt), 32'd0);
        check_output($sformatf("fair.cap0_c%0d", c), 32'(cap_en), 32'd0);
      end
    end
    check_output("fair.rr_end", 32'(dut.rr_ptr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_capture_reg_arbiter
